serial_parity_unit: RTL and testbench
=====================================

# serial_parity_unit

Parametrised serial parity generator/checker. It loads a WIDTH-bit word on a start handshake, then folds it into a parity accumulator one bit per clock. When the word is finished it reports the parity bit and, optionally, a mismatch against a received parity bit. It is the successor to the fixed 3-bit, even-only, reset-per-word checker: it adds configurable width, bit order, odd/even mode, a compare path, and back-to-back operation without a reset between words.

## Interface
Parameters:
- WIDTH, 8: word length in bits; legal range 2..64.
- MSB_FIRST, 1: 1 consumes bit WIDTH-1 first; 0 consumes bit 0 first. Parity is the same either way; only `cur_bit` order differs.

Ports:
- clk  in  1  single clock; rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request; sampled only when `ready`=1.
- word  in  WIDTH  data word; captured at the accepted start edge.
- odd_mode  in  1  0 = even parity (parity = XOR of bits); 1 = odd parity (parity = XNOR of bits). Captured at start.
- check_en  in  1  1 = compare the result against `rx_parity`. Captured at start.
- rx_parity  in  1  received parity bit. Captured at start.
- ready  out  1  high in IDLE and DONE; start is accepted only when high.
- busy  out  1  high in SHIFT.
- cur_bit  out  1  bit being consumed this cycle; 0 when not in SHIFT.
- bit_cnt  out  clog2(WIDTH+1)  number of bits consumed so far.
- done  out  1  one-cycle pulse; result valid.
- parity  out  1  computed parity bit; held until the next accepted start.
- error  out  1  check_en_q & (parity != rx_parity_q); held with `parity`.

## Operation
- FSM states are IDLE, SHIFT and DONE.
- IDLE: `ready`=1. On start=1:
  - load the shift register with `word`;
  - latch odd_mode, check_en and rx_parity;
  - set acc=0 and bit_cnt=0;
  - go to SHIFT.
- SHIFT: on each edge, acc ^= head bit, shift by one and bit_cnt += 1. The edge where bit_cnt becomes WIDTH goes to DONE, and on that edge parity = acc_final ^ odd_mode_q and error is registered.
- DONE: lasts exactly one cycle, with done=1 and ready=1.
  - start=1 here behaves exactly like start in IDLE (back-to-back); the next state is SHIFT.
  - Otherwise the next state is IDLE.
- start while busy=1 is ignored, with no side effects and no queueing.
- `parity` and `error` change only on the DONE-entry edge, on the accepted start edge (both cleared to 0), and on reset.
- When check_en_q=0, error is always 0.

## Timing
- Reset values: state IDLE, ready=1, busy=0, done=0, parity=0, error=0, bit_cnt=0, cur_bit=0, shift register 0.
- Start accepted at edge k:
  - busy=1 from k to k+WIDTH;
  - bits are consumed on edges k+1 .. k+WIDTH;
  - done=1 for the single cycle from k+WIDTH to k+WIDTH+1.
- Latency from start to done is WIDTH cycles. Throughput is one word per WIDTH+1 cycles (start is issued during DONE).
- Reset asserted mid-SHIFT aborts the word immediately (asynchronous). No done pulse is produced for the aborted word.
- Reset and start together: reset wins.
- Inputs other than start, word, odd_mode, check_en and rx_parity at the accepted edge do not affect the result.

## Structure
- Package `parity_pkg` holds:
  - the state enum (IDLE, SHIFT, DONE);
  - the bit_cnt width function;
  - the localparam for the legal WIDTH range.
- Sub-module `parity_accum`: a one-bit toggle accumulator with `clr`, `en` and `din` inputs, asynchronous reset, and output `acc`. The top level instantiates it once.
- The top level holds the FSM, shift register, counter and output registers.

## Test plan
- WIDTH=8, word=8'hA5, odd_mode=0, check_en=0 → done on cycle 8 after start, parity=0, error=0. Repeat with odd_mode=1 → parity=1.
- WIDTH=8, word=8'h01, odd_mode=0, check_en=1, rx_parity=0 → parity=1, error=1. Repeat with rx_parity=1 → error=0.
- WIDTH=8, MSB_FIRST=1, word=8'h80 → cur_bit=1 in the first SHIFT cycle then 0. With MSB_FIRST=0 → cur_bit=1 in the last SHIFT cycle.
- Back-to-back: start 8'hFF, then start 8'h7F during the DONE cycle → two done pulses 9 cycles apart with parity 0 then 1. A start pulsed mid-SHIFT is ignored.
- Reset asserted at bit_cnt=4 of word 8'h0F → all outputs return to reset values at once, and no done pulse follows. A fresh start of 8'h0F then gives parity=0.
- WIDTH=3: sweep words 0..7 in both modes, with and without a reset between words → parity = ^word ^ odd_mode in every case.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared types and sizing helpers for the serial parity generator/checker.
package parity_pkg;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // bit_cnt must be able to hold the value WIDTH itself
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/parity_accum.sv
// One-bit toggle accumulator: folds din into acc by XOR while en is high.
module parity_accum (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic din,
  output logic acc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= 1'b0;
    end else if (clr) begin
      acc <= 1'b0;
    end else if (en) begin
      acc <= acc ^ din;
    end
  end

endmodule

// File: rtl/serial_parity_unit.sv
// Serial parity generator/checker: consumes one word bit per clock and reports
// odd/even parity plus an optional mismatch against a received parity bit.
module serial_parity_unit
  import parity_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [WIDTH-1:0]            word,
  input  logic                        odd_mode,
  input  logic                        check_en,
  input  logic                        rx_parity,
  output logic                        ready,
  output logic                        busy,
  output logic                        cur_bit,
  output logic [cnt_width(WIDTH)-1:0] bit_cnt,
  output logic                        done,
  output logic                        parity,
  output logic                        error
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("serial_parity_unit: WIDTH out of range");
  end

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic             odd_q;
  logic             chk_q;
  logic             rx_q;
  logic             acc;
  logic             head;
  logic             accept;
  logic             last;
  logic             par_final;

  assign head      = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
  assign accept    = start && (state == IDLE || state == DONE);
  assign last      = (state == SHIFT) && (bit_cnt == LAST);
  // The accumulator has not yet absorbed the final head bit on the DONE-entry edge
  assign par_final = acc ^ head ^ odd_q;
  assign cur_bit   = busy & head;

  parity_accum u_accum (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .en    (state == SHIFT),
    .din   (head),
    .acc   (acc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sreg    <= '0;
      bit_cnt <= '0;
      odd_q   <= 1'b0;
      chk_q   <= 1'b0;
      rx_q    <= 1'b0;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      parity  <= 1'b0;
      error   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state   <= SHIFT;
            sreg    <= word;
            odd_q   <= odd_mode;
            chk_q   <= check_en;
            rx_q    <= rx_parity;
            bit_cnt <= '0;
            parity  <= 1'b0;
            error   <= 1'b0;
            ready   <= 1'b0;
            busy    <= 1'b1;
          end else begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end
        SHIFT: begin
          sreg    <= MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
          bit_cnt <= bit_cnt + CW'(1);
          if (last) begin
            state  <= DONE;
            ready  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b1;
            parity <= par_final;
            error  <= chk_q & (par_final ^ rx_q);
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_parity_unit.sv
// Bench for serial_parity_unit: WIDTH=8 in both bit orders plus a WIDTH=3 instance.
module tb_serial_parity_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       start8, start3;
  logic [7:0] word8;
  logic [2:0] word3;
  logic       odd_mode, check_en, rx_parity;

  logic       m_ready, m_busy, m_cur, m_done, m_par, m_err;
  logic [3:0] m_cnt;
  logic       l_ready, l_busy, l_cur, l_done, l_par, l_err;
  logic [3:0] l_cnt;
  logic       t_ready, t_busy, t_cur, t_done, t_par, t_err;
  logic [1:0] t_cnt;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  serial_parity_unit #(.WIDTH(8), .MSB_FIRST(1'b1)) u8m (
    .clk(clk), .reset(reset), .start(start8), .word(word8), .odd_mode(odd_mode),
    .check_en(check_en), .rx_parity(rx_parity), .ready(m_ready), .busy(m_busy),
    .cur_bit(m_cur), .bit_cnt(m_cnt), .done(m_done), .parity(m_par), .error(m_err));

  serial_parity_unit #(.WIDTH(8), .MSB_FIRST(1'b0)) u8l (
    .clk(clk), .reset(reset), .start(start8), .word(word8), .odd_mode(odd_mode),
    .check_en(check_en), .rx_parity(rx_parity), .ready(l_ready), .busy(l_busy),
    .cur_bit(l_cur), .bit_cnt(l_cnt), .done(l_done), .parity(l_par), .error(l_err));

  serial_parity_unit #(.WIDTH(3), .MSB_FIRST(1'b1)) u3 (
    .clk(clk), .reset(reset), .start(start3), .word(word3), .odd_mode(odd_mode),
    .check_en(check_en), .rx_parity(rx_parity), .ready(t_ready), .busy(t_busy),
    .cur_bit(t_cur), .bit_cnt(t_cnt), .done(t_done), .parity(t_par), .error(t_err));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: parity is the count of ones modulo 2, inverted in odd mode
  function automatic logic model_par(input logic [63:0] w, input int width, input logic odd);
    int ones = 0;
    for (int i = 0; i < width; i++) ones += int'(w[i]);
    return ((ones % 2) != 0) ^ odd;
  endfunction

  function automatic logic model_err(input logic chk, input logic rx, input logic par);
    return chk && (par != rx);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept8(input logic [7:0] w, input logic odd, input logic chk, input logic rx);
    word8 = w; odd_mode = odd; check_en = chk; rx_parity = rx; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    word8 = 8'($urandom); odd_mode = 1'($urandom);
    check_en = 1'($urandom); rx_parity = 1'($urandom);
    check("accept_busy", m_busy, 1);
    check("accept_ready", m_ready, 0);
    check("accept_cnt", m_cnt, 0);
    check("accept_par", m_par, 0);
    check("accept_err", m_err, 0);
  endtask

  task automatic shift8(input logic [7:0] w, input logic odd, input logic chk, input logic rx,
                        input int glitch);
    logic ep, ee;
    ep = model_par(64'(w), 8, odd);
    ee = model_err(chk, rx, ep);
    for (int i = 0; i < 8; i++) begin
      check("cur_msb", m_cur, w[7-i]);
      check("cur_lsb", l_cur, w[i]);
      check("shift_cnt", m_cnt, i);
      check("shift_done", m_done, 0);
      check("shift_busy", m_busy, 1);
      if (i == glitch) begin
        start8 = 1'b1;
        word8  = ~w;
      end
      tick();
      start8 = 1'b0;
    end
    check("done_m", m_done, 1);
    check("done_l", l_done, 1);
    check("done_ready", m_ready, 1);
    check("done_busy", m_busy, 0);
    check("done_cnt", m_cnt, 8);
    check("done_cur", m_cur, 0);
    check("par_m", m_par, ep);
    check("par_l", l_par, ep);
    check("err_m", m_err, ee);
    check("err_l", l_err, ee);
  endtask

  task automatic idle8(input logic [7:0] w, input logic odd, input logic chk, input logic rx);
    logic ep;
    ep = model_par(64'(w), 8, odd);
    tick();
    check("idle_done", m_done, 0);
    check("idle_ready", m_ready, 1);
    check("idle_busy", m_busy, 0);
    check("idle_par", m_par, ep);
    check("idle_err", m_err, model_err(chk, rx, ep));
  endtask

  task automatic run8(input logic [7:0] w, input logic odd, input logic chk, input logic rx);
    accept8(w, odd, chk, rx);
    shift8(w, odd, chk, rx, -1);
    idle8(w, odd, chk, rx);
  endtask

  task automatic run3(input logic [2:0] w, input logic odd, input logic chk, input logic rx,
                      input logic rst_after);
    logic ep;
    ep = model_par(64'(w), 3, odd);
    word3 = w; odd_mode = odd; check_en = chk; rx_parity = rx; start3 = 1'b1;
    tick();
    start3 = 1'b0;
    check("w3_busy", t_busy, 1);
    repeat (2) begin
      tick();
      check("w3_early_done", t_done, 0);
    end
    tick();
    check("w3_done", t_done, 1);
    check("w3_par", t_par, ep);
    check("w3_err", t_err, model_err(chk, rx, ep));
    if (rst_after) begin
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("w3_rst_par", t_par, 0);
    end else begin
      tick();
      check("w3_idle", t_ready, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] w;
    logic       o, c, r, b2b, saw_done;

    reset = 1'b1; start8 = 1'b0; start3 = 1'b0; word8 = '0; word3 = '0;
    odd_mode = 1'b0; check_en = 1'b0; rx_parity = 1'b0;
    repeat (2) tick();
    check("rst_ready", m_ready, 1);
    check("rst_busy", m_busy, 0);
    check("rst_done", m_done, 0);
    check("rst_par", m_par, 0);
    check("rst_err", m_err, 0);
    check("rst_cnt", m_cnt, 0);
    check("rst_cur", m_cur, 0);
    check("rst_ready3", t_ready, 1);
    reset = 1'b0;
    tick();

    run8(8'hA5, 1'b0, 1'b0, 1'b0);
    run8(8'hA5, 1'b1, 1'b0, 1'b0);
    run8(8'h01, 1'b0, 1'b1, 1'b0);
    run8(8'h01, 1'b0, 1'b1, 1'b1);
    run8(8'h80, 1'b0, 1'b0, 1'b0);

    // Back-to-back with a start pulsed mid-SHIFT of the second word
    accept8(8'hFF, 1'b0, 1'b0, 1'b0);
    shift8(8'hFF, 1'b0, 1'b0, 1'b0, -1);
    accept8(8'h7F, 1'b0, 1'b0, 1'b0);
    shift8(8'h7F, 1'b0, 1'b0, 1'b0, 3);
    idle8(8'h7F, 1'b0, 1'b0, 1'b0);

    // Asynchronous abort at bit_cnt=4
    accept8(8'h0F, 1'b0, 1'b1, 1'b1);
    repeat (4) tick();
    check("abort_cnt_before", m_cnt, 4);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", m_busy, 0);
    check("abort_ready", m_ready, 1);
    check("abort_cnt", m_cnt, 0);
    check("abort_cur", m_cur, 0);
    check("abort_done", m_done, 0);
    check("abort_par", m_par, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    saw_done = 1'b0;
    repeat (12) begin
      tick();
      saw_done = saw_done | m_done | l_done;
    end
    check("abort_no_done", saw_done, 0);
    run8(8'h0F, 1'b0, 1'b0, 1'b0);

    // Randomized words, mixing idle gaps and back-to-back starts
    b2b = 1'b0;
    for (int k = 0; k < 20; k++) begin
      w = 8'($urandom); o = 1'($urandom); c = 1'($urandom); r = 1'($urandom);
      accept8(w, o, c, r);
      shift8(w, o, c, r, int'($urandom_range(0, 9)));
      b2b = 1'($urandom);
      if (!b2b || k == 19) idle8(w, o, c, r);
    end

    // WIDTH=3 exhaustive sweep
    for (int rs = 0; rs < 2; rs++)
      for (int od = 0; od < 2; od++)
        for (int v = 0; v < 8; v++)
          run3(3'(v), 1'(od), 1'($urandom), 1'($urandom), 1'(rs));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
